// File: rtl/mc_stage_sequencer_pkg.sv
// Shared definitions for the multi-cycle stage sequencer: stage codes and timer sizing.
// Stage codes match the values the CPU top and trace monitors already decode.
package mc_stage_sequencer_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_IF   = 3'd0,
    ST_RR   = 3'd1,
    ST_EX   = 3'd2,
    ST_MA   = 3'd3,
    ST_RW   = 3'd4,
    ST_HALT = 3'd5
  } stage_e;

  // Counter width able to hold WAIT_MAX; never narrower than one bit.
  function automatic int timer_w(input int wait_max);
    return (wait_max < 1) ? 1 : $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/mc_stage_sequencer_mem_wait_timer.sv
// Counts MA cycles spent waiting on dmem_ack; flags the last allowed cycle.
// WAIT_MAX == 0 disables expiry entirely.
module mem_wait_timer
  import mc_stage_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = timer_w(WAIT_MAX);
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expire)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Expiry is raised during the WAIT_MAX-th waiting cycle so the FSM leaves MA right after it.
  generate
    if (WAIT_MAX == 0) begin : g_no_timeout
      assign expire = 1'b0;
    end else begin : g_timeout
      assign expire = enable && (cnt_q == W'(WAIT_MAX - 1));
    end
  endgenerate

endmodule

// File: rtl/mc_stage_sequencer.sv
// Multi-cycle IF/RR/EX/MA/RW control FSM: owns the PC, clears, write strobes and perf counters.
// Every output is a flop loaded from the stage being entered.
module mc_stage_sequencer
  import mc_stage_sequencer_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h7FFC,
  parameter int              SKIP_MA  = 1,
  parameter int              WAIT_MAX = 16,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  npc,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             reg_we_state,
  input  logic             imem_ready,
  input  logic             stall_req,
  input  logic             dmem_ack,
  output logic [XLEN-1:0]  pc,
  output logic [2:0]       stage,
  output logic             decoder_rst,
  output logic             alu_rst,
  output logic             dmem_req,
  output logic             ram_we,
  output logic             reg_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  stage_e            stage_q, stage_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              decoder_rst_q, decoder_rst_d;
  logic              alu_rst_q, alu_rst_d;
  logic              dmem_req_q, dmem_req_d;
  logic              ram_we_q, ram_we_d;
  logic              reg_we_q, reg_we_d;
  logic              halted_q, halted_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instret_cnt_q, instret_cnt_d;

  logic mem_op, in_ma, ma_expire;

  assign mem_op = is_load | is_store;
  assign in_ma  = (stage_q == ST_MA);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_ma),
    .enable (in_ma && mem_op),
    .expire (ma_expire)
  );

  always_comb begin
    stage_d       = stage_q;
    pc_d          = pc_q;
    bus_err_d     = bus_err_q;
    instret_cnt_d = instret_cnt_q;
    cycle_cnt_d   = halted_q ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;

    case (stage_q)
      ST_IF: if (imem_ready && !stall_req) stage_d = ST_RR;
      ST_RR: stage_d = ST_EX;
      ST_EX: stage_d = (mem_op || SKIP_MA == 0) ? ST_MA : ST_RW;
      ST_MA: begin
        // An ack arriving in the expiry cycle still completes the access.
        if (!mem_op || dmem_ack) begin
          stage_d = ST_RW;
        end else if (ma_expire) begin
          stage_d   = ST_HALT;
          bus_err_d = 1'b1;
        end
      end
      ST_RW: begin
        instret_cnt_d = instret_cnt_q + CNT_ONE;
        if (is_halt) begin
          stage_d = ST_HALT;
        end else begin
          pc_d    = {npc[XLEN-1:2], 2'b00};
          stage_d = ST_IF;
        end
      end
      ST_HALT: stage_d = ST_HALT;
      default: stage_d = ST_IF;
    endcase

    decoder_rst_d = (stage_d == ST_RR);
    alu_rst_d     = (stage_d == ST_EX);
    dmem_req_d    = (stage_d == ST_MA) && mem_op;
    ram_we_d      = dmem_req_d && is_store;
    reg_we_d      = (stage_d == ST_RW) && reg_we_state;
    halted_d      = (stage_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q       <= ST_IF;
      pc_q          <= RESET_PC;
      decoder_rst_q <= 1'b0;
      alu_rst_q     <= 1'b0;
      dmem_req_q    <= 1'b0;
      ram_we_q      <= 1'b0;
      reg_we_q      <= 1'b0;
      halted_q      <= 1'b0;
      bus_err_q     <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      stage_q       <= stage_d;
      pc_q          <= pc_d;
      decoder_rst_q <= decoder_rst_d;
      alu_rst_q     <= alu_rst_d;
      dmem_req_q    <= dmem_req_d;
      ram_we_q      <= ram_we_d;
      reg_we_q      <= reg_we_d;
      halted_q      <= halted_d;
      bus_err_q     <= bus_err_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign stage       = stage_q;
  assign decoder_rst = decoder_rst_q;
  assign alu_rst     = alu_rst_q;
  assign dmem_req    = dmem_req_q;
  assign ram_we      = ram_we_q;
  assign reg_we      = reg_we_q;
  assign halted      = halted_q;
  assign bus_err     = bus_err_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Bench for mc_stage_sequencer: per-instruction timeline model checked every cycle,
// two DUT configurations (SKIP_MA=1/CNT_W=4/WAIT_MAX=16 and SKIP_MA=0/CNT_W=8/WAIT_MAX=4).
module tb_mc_stage_sequencer;

  localparam int S_IF = 0, S_RR = 1, S_EX = 2, S_MA = 3, S_RW = 4, S_HALT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, sel = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] npc = '0;
  logic        is_load = 0, is_store = 0, is_halt = 0, reg_we_state = 0;
  logic        imem_ready = 0, stall_req = 0, dmem_ack = 0;

  assign rst_a = sel ? 1'b1 : rst;
  assign rst_b = sel ? rst : 1'b1;

  logic [31:0] a_pc, b_pc;
  logic [2:0]  a_stage, b_stage;
  logic        a_dec, a_alu, a_req, a_we, a_rwe, a_halted, a_bus;
  logic        b_dec, b_alu, b_req, b_we, b_rwe, b_halted, b_bus;
  logic [3:0]  a_cyc, a_inst;
  logic [7:0]  b_cyc, b_inst;

  mc_stage_sequencer #(.XLEN(32), .RESET_PC(32'h7FFC), .SKIP_MA(1), .WAIT_MAX(16), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .npc(npc), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
    .reg_we_state(reg_we_state), .imem_ready(imem_ready), .stall_req(stall_req), .dmem_ack(dmem_ack),
    .pc(a_pc), .stage(a_stage), .decoder_rst(a_dec), .alu_rst(a_alu), .dmem_req(a_req), .ram_we(a_we),
    .reg_we(a_rwe), .halted(a_halted), .bus_err(a_bus), .cycle_cnt(a_cyc), .instret_cnt(a_inst));

  mc_stage_sequencer #(.XLEN(32), .RESET_PC(32'h7FFC), .SKIP_MA(0), .WAIT_MAX(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .npc(npc), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
    .reg_we_state(reg_we_state), .imem_ready(imem_ready), .stall_req(stall_req), .dmem_ack(dmem_ack),
    .pc(b_pc), .stage(b_stage), .decoder_rst(b_dec), .alu_rst(b_alu), .dmem_req(b_req), .ram_we(b_we),
    .reg_we(b_rwe), .halted(b_halted), .bus_err(b_bus), .cycle_cnt(b_cyc), .instret_cnt(b_inst));

  logic [31:0] d_pc, d_stage, d_cyc, d_inst;
  logic        d_dec, d_alu, d_req, d_we, d_rwe, d_halted, d_bus;
  always_comb begin
    d_pc = sel ? b_pc : a_pc;
    d_stage = {29'b0, sel ? b_stage : a_stage};
    d_cyc = sel ? {24'b0, b_cyc} : {28'b0, a_cyc};
    d_inst = sel ? {24'b0, b_inst} : {28'b0, a_inst};
    d_dec = sel ? b_dec : a_dec;
    d_alu = sel ? b_alu : a_alu;
    d_req = sel ? b_req : a_req;
    d_we = sel ? b_we : a_we;
    d_rwe = sel ? b_rwe : a_rwe;
    d_halted = sel ? b_halted : a_halted;
    d_bus = sel ? b_bus : a_bus;
  end

  // Model state: what the current cycle must show, plus the running counters.
  int          e_stage = S_IF;
  logic        e_dec = 0, e_alu = 0, e_req = 0, e_we = 0, e_rwe = 0, e_halt = 0, e_bus = 0;
  logic [31:0] e_pc = 32'h7FFC;
  int unsigned e_cyc = 0, e_inst = 0, cnt_mask = 32'hF;
  bit          skip_ma = 1, chk_en = 0;
  int          wait_max = 16;
  int          n_tests = 0, n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stage", d_stage, e_stage);
      cmp("pc", d_pc, e_pc);
      cmp("decoder_rst", {31'b0, d_dec}, {31'b0, e_dec});
      cmp("alu_rst", {31'b0, d_alu}, {31'b0, e_alu});
      cmp("dmem_req", {31'b0, d_req}, {31'b0, e_req});
      cmp("ram_we", {31'b0, d_we}, {31'b0, e_we});
      cmp("reg_we", {31'b0, d_rwe}, {31'b0, e_rwe});
      cmp("halted", {31'b0, d_halted}, {31'b0, e_halt});
      cmp("bus_err", {31'b0, d_bus}, {31'b0, e_bus});
      cmp("cycle_cnt", d_cyc, e_cyc & cnt_mask);
      cmp("instret_cnt", d_inst, e_inst & cnt_mask);
    end
  end

  task automatic set_exp(input int st, input bit dec, alu, req, we, rwe);
    e_stage = st; e_dec = dec; e_alu = alu; e_req = req; e_we = we; e_rwe = rwe;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (!rst) begin
      if (!e_halt) e_cyc++;
      if (e_stage == S_RW) e_inst++;
    end
  endtask

  task automatic clear_dec();
    is_load = 0; is_store = 0; is_halt = 0; reg_we_state = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst = 1; imem_ready = 0; stall_req = 0; clear_dec();
    tick();
    e_pc = 32'h7FFC; e_halt = 0; e_bus = 0; e_cyc = 0; e_inst = 0;
    set_exp(S_IF, 0, 0, 0, 0, 0);
    chk_en = 1;
    tick();
    rst = 0;
  endtask

  // One instruction: if_wait idle IF cycles, then RR, EX, optional MA, RW.
  task automatic instr(input int if_wait, input bit stall, input bit ld, input bit st, input bit hlt,
                       input bit rwe, input logic [31:0] npc_v, input int ack_dly, input int rst_at);
    for (int i = 0; i < if_wait; i++) begin
      set_exp(S_IF, 0, 0, 0, 0, 0);
      imem_ready = stall; stall_req = stall;
      tick();
    end
    set_exp(S_IF, 0, 0, 0, 0, 0);
    imem_ready = 1; stall_req = 0;
    tick();
    imem_ready = 0;
    is_load = ld; is_store = st; is_halt = hlt; reg_we_state = rwe; npc = npc_v;
    set_exp(S_RR, 1, 0, 0, 0, 0); tick();
    set_exp(S_EX, 0, 1, 0, 0, 0); tick();
    if (ld || st) begin
      for (int k = 0; k < 256; k++) begin
        set_exp(S_MA, 0, 0, 1, st, 0);
        if (k == rst_at) begin
          do_reset();
          return;
        end
        dmem_ack = (k == ack_dly);
        tick();
        if (k == ack_dly) break;
        if (wait_max != 0 && k == wait_max - 1) begin
          e_bus = 1; e_halt = 1;
          clear_dec();
          return;
        end
      end
      dmem_ack = 0;
    end else if (!skip_ma) begin
      set_exp(S_MA, 0, 0, 0, 0, 0); tick();
    end
    set_exp(S_RW, 0, 0, 0, 0, rwe); tick();
    if (hlt) e_halt = 1;
    else     e_pc = {npc_v[31:2], 2'b00};
    clear_dec();
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_exp(S_HALT, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Configuration A: SKIP_MA=1, WAIT_MAX=16, CNT_W=4
    sel = 0; skip_ma = 1; wait_max = 16; cnt_mask = 32'hF;
    do_reset();
    cmp("lit_rst_pc", a_pc, 32'h7FFC);
    cmp("lit_rst_stage", {29'b0, a_stage}, 32'd0);

    instr(0, 0, 0, 0, 0, 1, 32'h8000, 0, -1);
    cmp("lit_add_pc", a_pc, 32'h8000);
    cmp("lit_add_instret", {28'b0, a_inst}, 32'd1);

    instr(3, 0, 0, 0, 0, 1, 32'h8013, 0, -1);
    cmp("lit_wait_pc", a_pc, 32'h8010);
    cmp("lit_wait_cyc", {28'b0, a_cyc}, 32'd11);
    instr(3, 1, 0, 0, 0, 1, 32'h8020, 0, -1);
    instr(0, 0, 0, 1, 0, 0, 32'h8024, 2, -1);
    instr(0, 0, 1, 0, 0, 1, 32'h8028, 0, -1);
    instr(0, 0, 0, 0, 1, 0, 32'h9000, 0, -1);
    halt_cycles(3);
    cmp("lit_halt_flag", {31'b0, a_halted}, 32'd1);
    cmp("lit_halt_pc", a_pc, 32'h8028);
    cmp("lit_halt_instret", {28'b0, a_inst}, 32'd6);

    do_reset();
    instr(0, 0, 1, 0, 0, 1, 32'h8000, 1000, -1);
    halt_cycles(2);
    cmp("lit_to_bus_err", {31'b0, a_bus}, 32'd1);
    cmp("lit_to_pc", a_pc, 32'h7FFC);
    cmp("lit_to_instret", {28'b0, a_inst}, 32'd0);

    do_reset();
    instr(0, 0, 1, 1, 0, 0, 32'h8000, 1000, 2);
    cmp("lit_midma_pc", a_pc, 32'h7FFC);
    cmp("lit_midma_req", {31'b0, a_req}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      instr(0, 0, 0, 0, 0, 1, 32'h8000 + 32'(i * 4), 0, -1);
      if (i == 14) cmp("lit_inst_15", {28'b0, a_inst}, 32'd15);
    end
    cmp("lit_inst_wrap", {28'b0, a_inst}, 32'd0);

    // Configuration B: SKIP_MA=0, WAIT_MAX=4, CNT_W=8
    chk_en = 0;
    sel = 1; skip_ma = 0; wait_max = 4; cnt_mask = 32'hFF;
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 32'h8000, 0, -1);
    cmp("lit_b_add_cyc", {24'b0, b_cyc}, 32'd5);
    cmp("lit_b_add_pc", b_pc, 32'h8000);
    instr(0, 0, 1, 0, 0, 1, 32'h8040, 1, -1);
    instr(0, 0, 0, 1, 0, 0, 32'h8080, 1000, -1);
    halt_cycles(2);
    cmp("lit_b_bus_err", {31'b0, b_bus}, 32'd1);
    cmp("lit_b_pc", b_pc, 32'h8040);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
